// File: rtl/gf_array_feeder.sv
// rtl/gf_array_feeder.sv - operand feeder that serialises buffered GF(2^8) operand pairs into 8-cycle array frames
//
// Purpose: buffers (A, B) operand pairs in a 2-entry FIFO and plays each pair
// out as an 8-cycle frame to a bit-serial GF(2^8) multiplier array, together
// with the field polynomial captured when the pair was popped. An optional
// number of idle cycles (GAP) follows every frame.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand pair handshake, in_a/in_b the operands
//   poly_we/poly_d  field-polynomial register write
//   ai, gi, bi      A / polynomial / B words to the array (0 outside frames)
//   pi              A bit for frame cycle k, MSB first
//   ctr             0 on frame cycle 0 (load), 1 while accumulating
//   frame_start     high on frame cycle 0, frame_last high on frame cycle 7
//   busy            work pending (FIFO non-empty or not idle)
//   frames_sent     completed-frame counter, wraps
module gf_array_feeder #(
  parameter int          GAP      = 0,
  parameter logic [7:0]  POLY_RST = 8'h1B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        poly_we,
  input  logic [7:0]  poly_d,
  output logic [7:0]  ai,
  output logic [7:0]  gi,
  output logic [7:0]  bi,
  output logic        pi,
  output logic        ctr,
  output logic        frame_start,
  output logic        frame_last,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

  // Index of the last GAP cycle; that cycle's edge behaves like IDLE so that
  // exactly GAP empty cycles separate two queued frames.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] fifo_q [2];
  logic [15:0] fifo_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  sa_q, sa_d, sb_q, sb_d, sg_q, sg_d;
  logic [7:0]  preg_q, preg_d;
  logic [15:0] sent_q, sent_d;
  logic        rdy_q, rdy_d, busy_q, busy_d;
  logic [7:0]  ai_q, ai_d, gi_q, gi_d, bi_q, bi_d;
  logic        pi_q, pi_d, ctr_q, ctr_d, fs_q, fs_d, fl_q, fl_d;
  logic        push, pop, start, in_frame;

  always_comb begin
    push    = in_valid && rdy_q;
    pop     = 1'b0;
    start   = 1'b0;
    state_d = state_q;
    k_d     = k_q;
    gap_d   = gap_q;
    sent_d  = sent_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sg_d    = sg_q;

    unique case (state_q)
      S_IDLE:  start = 1'b1;
      S_FRAME: begin
        if (k_q == 3'd7) begin
          sent_d = sent_q + 16'd1;
          if (GAP == 0) begin
            start = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = 4'd0;
          end
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) start = 1'b1;
        else                   gap_d = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame launch: the polynomial is captured from the register's current
    // value, so a write at this same edge only reaches later frames.
    if (start) begin
      if (cnt_q != 2'd0) begin
        pop     = 1'b1;
        state_d = S_FRAME;
        k_d     = 3'd0;
        sa_d    = fifo_q[0][15:8];
        sb_d    = fifo_q[0][7:0];
        sg_d    = preg_q;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Head is always entry 0; pop shifts first, then a push lands at the
    // first free slot, which keeps order for a simultaneous push and pop.
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (push) begin
      fifo_d[cnt_d[0]] = {in_a, in_b};
      cnt_d            = cnt_d + 2'd1;
    end

    preg_d = poly_we ? poly_d : preg_q;

    in_frame = (state_d == S_FRAME);
    ai_d     = in_frame ? sa_d : 8'd0;
    gi_d     = in_frame ? sg_d : 8'd0;
    bi_d     = in_frame ? sb_d : 8'd0;
    pi_d     = in_frame && sa_d[3'd7 - k_d];
    ctr_d    = in_frame && (k_d != 3'd0);
    fs_d     = in_frame && (k_d == 3'd0);
    fl_d     = in_frame && (k_d == 3'd7);
    busy_d   = (state_d != S_IDLE) || (cnt_d != 2'd0);
    rdy_d    = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= 3'd0;
      gap_q     <= 4'd0;
      fifo_q[0] <= 16'd0;
      fifo_q[1] <= 16'd0;
      cnt_q     <= 2'd0;
      sa_q      <= 8'd0;
      sb_q      <= 8'd0;
      sg_q      <= 8'd0;
      preg_q    <= POLY_RST;
      sent_q    <= 16'd0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      ai_q      <= 8'd0;
      gi_q      <= 8'd0;
      bi_q      <= 8'd0;
      pi_q      <= 1'b0;
      ctr_q     <= 1'b0;
      fs_q      <= 1'b0;
      fl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      gap_q     <= gap_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      cnt_q     <= cnt_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      sg_q      <= sg_d;
      preg_q    <= preg_d;
      sent_q    <= sent_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      ai_q      <= ai_d;
      gi_q      <= gi_d;
      bi_q      <= bi_d;
      pi_q      <= pi_d;
      ctr_q     <= ctr_d;
      fs_q      <= fs_d;
      fl_q      <= fl_d;
    end
  end

  assign in_ready    = rdy_q;
  assign ai          = ai_q;
  assign gi          = gi_q;
  assign bi          = bi_q;
  assign pi          = pi_q;
  assign ctr         = ctr_q;
  assign frame_start = fs_q;
  assign frame_last  = fl_q;
  assign busy        = busy_q;
  assign frames_sent = sent_q;

endmodule
